// File: rtl/calc_if.sv
// Switch/button inputs and display/result outputs of calc_sequencer, bundled.
interface calc_if;
  logic [3:0] sw;
  logic       op_sel;
  logic       btn;
  logic [3:0] result;
  logic       carry;
  logic       done;
  logic [1:0] state;
  logic [3:0] an;
  logic [6:0] seg;

  modport master (
    output sw, op_sel, btn,
    input  result, carry, done, state, an, seg
  );

  modport slave (
    input  sw, op_sel, btn,
    output result, carry, done, state, an, seg
  );
endinterface

// File: rtl/calc_sequencer.sv
// Operand entry / add-subtract sequencer with a four-digit seven-segment scan.
// Optional CALC_OVF_BLANK_EN: result digit shows the error glyph whenever carry is set.
module calc_sequencer #(
  parameter int unsigned SCAN_DIV = 16
) (
  input  logic   clk,
  input  logic   rst,
  calc_if.slave  bus
);

  // state  | meaning
  // LOAD_A | digit A tracks sw, go latches A
  // LOAD_B | digit B tracks sw, go latches B and op
  // EXEC   | one-cycle add/subtract
  // SHOW   | hold result, go returns to LOAD_A
  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    EXEC   = 2'b10,
    SHOW   = 2'b11
  } state_t;

  localparam logic [15:0] CNT_MAX   = 16'(SCAN_DIV - 1);
  localparam logic [6:0]  GLYPH_ERR = 7'b0011101;
  localparam logic [6:0]  GLYPH_ADD = 7'b0110001;
  localparam logic [6:0]  GLYPH_SUB = 7'b0000001;

  state_t      state_q, state_d;
  logic [3:0]  a_q, a_d, b_q, b_d, result_q, result_d;
  logic        op_q, op_d, carry_q, carry_d, done_q, done_d;
  logic        btn_q;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        go;
  logic [4:0]  sum;

  function automatic logic [6:0] dec7(input logic [3:0] v);
    case (v)
      4'd0:    dec7 = 7'b1111110;
      4'd1:    dec7 = 7'b0110000;
      4'd2:    dec7 = 7'b1101101;
      4'd3:    dec7 = 7'b1111001;
      4'd4:    dec7 = 7'b0110011;
      4'd5:    dec7 = 7'b1011011;
      4'd6:    dec7 = 7'b1011111;
      4'd7:    dec7 = 7'b1110000;
      4'd8:    dec7 = 7'b1111111;
      4'd9:    dec7 = 7'b1111011;
      default: dec7 = GLYPH_ERR;
    endcase
  endfunction

  always_comb begin
    go       = bus.btn & ~btn_q;
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    carry_d  = carry_q;
    done_d   = 1'b0;
    sum      = 5'd0;

    case (state_q)
      LOAD_A: if (go) begin
        a_d     = bus.sw;
        state_d = LOAD_B;
      end
      LOAD_B: if (go) begin
        b_d     = bus.sw;
        op_d    = bus.op_sel;
        state_d = EXEC;
      end
      EXEC: begin
        // bit 4 of the zero-extended difference is the borrow
        sum      = op_q ? ({1'b0, a_q} + {1'b0, b_q}) : ({1'b0, a_q} - {1'b0, b_q});
        result_d = sum[3:0];
        carry_d  = sum[4];
        done_d   = 1'b1;
        state_d  = SHOW;
      end
      SHOW: if (go) state_d = LOAD_A;
      default: state_d = LOAD_A;
    endcase

    if (cnt_q == CNT_MAX) begin
      cnt_d = 16'd0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + 16'd1;
      idx_d = idx_q;
    end

    // Display registers are built from next-cycle values so an/seg line up with idx_q.
    an_d = ~(4'b0001 << idx_d);
    case (idx_d)
      2'd0: begin
`ifdef CALC_OVF_BLANK_EN
        seg_d = carry_d ? GLYPH_ERR : dec7(result_d);
`else
        seg_d = dec7(result_d);
`endif
      end
      2'd1:    seg_d = (state_d == LOAD_B) ? dec7(bus.sw) : dec7(b_d);
      2'd2:    seg_d = (state_d == LOAD_A) ? dec7(bus.sw) : dec7(a_d);
      default: seg_d = op_d ? GLYPH_ADD : GLYPH_SUB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LOAD_A;
      a_q      <= 4'd0;
      b_q      <= 4'd0;
      op_q     <= 1'b1;
      result_q <= 4'd0;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
      btn_q    <= bus.btn;   // a button held through reset must not produce go
      cnt_q    <= 16'd0;
      idx_q    <= 2'd0;
      an_q     <= 4'b1110;
      seg_q    <= 7'b1111110;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      done_q   <= done_d;
      btn_q    <= bus.btn;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign bus.result = result_q;
  assign bus.carry  = carry_q;
  assign bus.done   = done_q;
  assign bus.state  = state_q;
  assign bus.an     = an_q;
  assign bus.seg    = seg_q;

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Sequencing controller for the 4-bit add/subtract datapath and its seven-segment decoder. Walks the user through operand entry (A, then B), runs one add or subtract, holds the result with carry/borrow, and time-multiplexes four seven-segment digits showing A, B, the operation glyph and the result. Sits between the debounced board switches/button and the display pins.

## Interface
Parameters:
- SCAN_DIV, 16: clock cycles each digit stays enabled; legal range 2..65535.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- sw  in  4  operand value from switches.
- op_sel  in  1  1 = add, 0 = subtract; sampled when B is latched.
- btn  in  1  debounced "next" button, level; the block edge-detects it.
- result  out  4  low nibble of the last operation.
- carry  out  1  add carry-out, or subtract borrow (A < B).
- done  out  1  one-cycle pulse when result/carry update.
- state  out  2  current FSM state encoding.
- an  out  4  digit enables, active-low, one-hot-zero.
- seg  out  7  segments a..g on bits 6..0, active-high.

## Operation
- Edge detect: btn_q registers btn; go = btn & ~btn_q. A held button yields exactly one go.
- FSM, encoding in parentheses:
  - LOAD_A (00): on go, A <= sw, go to LOAD_B.
  - LOAD_B (01): on go, B <= sw, op <= op_sel, go to EXEC.
  - EXEC (10): unconditionally {carry,result} <= op ? A+B : A-B (5-bit, zero-extended operands; subtract borrow = bit 4 of A-B), done <= 1, go to SHOW.
  - SHOW (11): on go, go to LOAD_A. A, B, op, result and carry are kept until overwritten.
- go outside LOAD_A/LOAD_B/SHOW (i.e. in EXEC) is ignored, not queued.
- Decoder for digit values: 0->1111110, 1->0110000, 2->1101101, 3->1111001, 4->0110011, 5->1011011, 6->1011111, 7->1110000, 8->1111111, 9->1111011, 10..15->0011101 (error glyph).
- Scan: counter 0..SCAN_DIV-1; on wrap, digit index (2 bits) increments mod 4.
  - index 0: an=1110, result digit.
  - index 1: an=1101, B.
  - index 2: an=1011, A.
  - index 3: an=0111, op glyph: add 0110001, subtract 0000001.
- In LOAD_A, digit A shows live sw; in LOAD_B, digit B shows live sw. Otherwise latched values.

## Timing
- Reset values: state=LOAD_A, A=B=0, op=1, result=0, carry=0, done=0, btn_q=0, scan counter=0, index=0, an=1110, seg=1111110.
- go at edge N: latch and state change visible after edge N+1 sample point (registered, 1-cycle).
- EXEC lasts exactly one cycle; result, carry, done valid the cycle after EXEC; done high one cycle only.
- LOAD_B go to result valid: 2 cycles.
- an/seg registered; each digit enabled exactly SCAN_DIV consecutive cycles; full frame 4*SCAN_DIV.
- Reset mid-operation (any state) returns everything to reset values next cycle; a btn held through reset release produces no go (btn_q reset to 0 is overridden: btn_q loads btn during reset).

## Configuration
- CALC_OVF_BLANK_EN defined: when carry=1, result digit shows error glyph 0011101 regardless of result value.
- Undefined: result digit always shows the decoded result nibble; carry only on the carry port.

## Test plan
- A=3, B=4, op_sel=1 -> result=7, carry=0, done pulse one cycle, result digit seg=1110000.
- A=9, B=8, add -> result=1, carry=1; result digit 0110000 without macro, 0011101 with CALC_OVF_BLANK_EN.
- A=2, B=5, op_sel=0 -> result=13, carry=1, result digit 0011101; op digit 0000001.
- SCAN_DIV=4, idle: an sequence 1110,1101,1011,0111 each exactly 4 cycles, repeating.
- btn held high 20 cycles in LOAD_A -> single advance to LOAD_B only; B not latched.
- Assert rst in LOAD_B with A=6 -> state=LOAD_A, A=0, an=1110, seg=1111110 next cycle.
